// File: rtl/crash_detect.sv
// Per-pixel collision detector: compares player, bullet and enemy alpha layers,
// emits same-cycle crash strobes, and owns lives, invincibility and game-over.
module crash_detect #(
  parameter int ENEMY_TYPES    = 3,
  parameter int ME_LIFE        = 3,
  parameter int LIFE_BIT_LEN   = 2,
  parameter int INVINC_FRAMES  = 60,
  parameter int INVINC_BIT_LEN = 6
) (
  input  logic                    clk_vga,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic                    v_sync_i,
  input  logic                    me_alpha_i,
  input  logic                    bullet_alpha_i,
  input  logic [ENEMY_TYPES-1:0]  enemy_alpha_i,
  output logic [ENEMY_TYPES-1:0]  crash_enemy_bullet_o,
  output logic [ENEMY_TYPES-1:0]  crash_me_enemy_o,
  output logic                    crash_bullet_o,
  output logic [LIFE_BIT_LEN-1:0] me_life_o,
  output logic                    invinc_o,
  output logic                    game_over_o
);

  logic                      vs_q;
  logic [ENEMY_TYPES-1:0]    hit_done_q, hit_done_d;
  logic                      me_done_q, me_done_d;
  logic [LIFE_BIT_LEN-1:0]   life_q, life_d;
  logic [INVINC_BIT_LEN-1:0] invinc_q, invinc_d;

  logic                   frame_edge;
  logic                   game_over;
  logic                   active;
  logic [ENEMY_TYPES-1:0] me_crash;
  logic [ENEMY_TYPES-1:0] hit;

  assign frame_edge = v_sync_i & ~vs_q;
  assign game_over  = (life_q == '0);
  assign active     = en_i & ~game_over & ~rst;

  // A player crash on a type suppresses the bullet hit on that same type.
  assign me_crash = {ENEMY_TYPES{active & ~me_done_q & (invinc_q == '0) & me_alpha_i}}
                    & enemy_alpha_i;
  assign hit      = {ENEMY_TYPES{active & bullet_alpha_i}} & ~hit_done_q
                    & enemy_alpha_i & ~me_crash;

  assign crash_me_enemy_o     = me_crash;
  assign crash_enemy_bullet_o = hit;
  assign crash_bullet_o       = |hit;
  assign me_life_o            = life_q;
  assign invinc_o             = (invinc_q != '0);
  assign game_over_o          = game_over;

  always_comb begin
    hit_done_d = hit_done_q;
    me_done_d  = me_done_q;
    life_d     = life_q;
    invinc_d   = invinc_q;
    if (en_i && frame_edge) begin
      hit_done_d = '0;
      me_done_d  = 1'b0;
      if (invinc_q != '0) invinc_d = invinc_q - INVINC_BIT_LEN'(1);
    end
    // Crash updates come last so they override the frame-boundary clear.
    hit_done_d = hit_done_d | hit;
    if (|me_crash) begin
      me_done_d = 1'b1;
      life_d    = life_q - LIFE_BIT_LEN'(1);
      invinc_d  = INVINC_BIT_LEN'(INVINC_FRAMES);
    end
  end

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      vs_q       <= 1'b0;
      hit_done_q <= '0;
      me_done_q  <= 1'b0;
      life_q     <= LIFE_BIT_LEN'(ME_LIFE);
      invinc_q   <= '0;
    end else begin
      vs_q       <= v_sync_i;
      hit_done_q <= hit_done_d;
      me_done_q  <= me_done_d;
      life_q     <= life_d;
      invinc_q   <= invinc_d;
    end
  end

endmodule

// File: doc/crash_detect.md
# crash_detect

Per-pixel collision detector in the `clk_vga` domain, sitting directly upstream of the enemy blocks. It compares the alpha outputs of the player-plane, player-bullet and enemy layers for the pixel currently being scanned. It emits same-cycle crash strobes to the enemy blocks (`crash_enemy_bullet_i` / `crash_me_enemy_i`) and a strobe to the bullet block. It rate-limits hits to one per enemy type per frame, and owns the player life counter, post-crash invincibility window and game-over flag.

## Interface
Parameters:
- `ENEMY_TYPES`, 3: number of enemy layers; one alpha input and one strobe pair per type.
- `ME_LIFE`, 3: player lives after reset.
- `LIFE_BIT_LEN`, 2: width of the life counter; must hold `ME_LIFE`.
- `INVINC_FRAMES`, 60: frames of invincibility after a player crash.
- `INVINC_BIT_LEN`, 6: width of the invincibility counter; must hold `INVINC_FRAMES`.

Ports:
- `clk_vga`  in  1: pixel clock, the only clock.
- `rst`  in  1: reset; one clock; reset is asynchronous and active-high.
- `en_i`  in  1: game running; 0 freezes all state and forces strobes low.
- `v_sync_i`  in  1: vertical sync; rising edge marks the frame boundary.
- `me_alpha_i`  in  1: player-plane pixel opaque.
- `bullet_alpha_i`  in  1: player-bullet layer pixel opaque.
- `enemy_alpha_i`  in  `ENEMY_TYPES`: bit k = enemy type k pixel opaque (bit 2 = enemy3).
- `crash_enemy_bullet_o`  out  `ENEMY_TYPES`: bit k = bullet hit on type k this cycle.
- `crash_me_enemy_o`  out  `ENEMY_TYPES`: bit k = player collided with type k this cycle.
- `crash_bullet_o`  out  1: a bullet was consumed by a hit this cycle.
- `me_life_o`  out  `LIFE_BIT_LEN`: remaining player lives.
- `invinc_o`  out  1: invincibility window active.
- `game_over_o`  out  1: lives exhausted; sticky until `rst`.

## Operation
- Registered state:
  - `vs_d`: previous `v_sync_i`.
  - `hit_done[k]`: bullet hit already reported for type k this frame.
  - `me_done`: player crash already reported this frame.
  - `life`, `invinc_cnt`.
- Frame edge: `frame_edge = v_sync_i & ~vs_d`. `vs_d` updates every cycle, including when `en_i`=0.
- Player crash on type k: `me_crash_k = en & ~game_over & ~me_done & (invinc_cnt==0) & me_alpha_i & enemy_alpha_i[k]`.
- Bullet hit on type k: `hit_k = en & ~game_over & ~hit_done[k] & bullet_alpha_i & enemy_alpha_i[k] & ~me_crash_k`. A player crash takes precedence over a bullet hit on the same type in the same cycle; `hit_done[k]` is then not set.
- Strobes:
  - `crash_me_enemy_o[k] = me_crash_k`.
  - `crash_enemy_bullet_o[k] = hit_k`.
  - `crash_bullet_o = |hit`.
- Several types may strobe in the same cycle; each type is independent.
- On any `hit_k`, set `hit_done[k]`.
- On any `me_crash_k`:
  - set `me_done`;
  - `life <= life - 1` (exactly one decrement, even if several types strobe together);
  - `invinc_cnt <= INVINC_FRAMES`.
- On `frame_edge` with `en_i`=1:
  - clear all `hit_done` and `me_done`;
  - if `invinc_cnt != 0`, decrement it.
- If `frame_edge` and a crash occur in the same cycle, the crash-set of `me_done`/`hit_done` wins. The `invinc_cnt` load also wins over the frame decrement.
- `game_over_o = (life == 0)`. Once set, all strobes are 0 and `life` never changes until `rst`.
- `life` never wraps: decrement only when nonzero, which is guaranteed by the `~game_over` gating.
- `invinc_o = (invinc_cnt != 0)`.
- `en_i`=0: strobes 0; `hit_done`, `me_done`, `life`, `invinc_cnt` hold.

## Timing
- Strobes are combinational from the current-cycle alphas and registered state, with zero latency. They are valid in the same `clk_vga` cycle as the pixel, so the enemy block samples them against its current `curr_enemy_idx`.
- Each strobe is high for at most one cycle per type per frame; an overlapping region many pixels wide yields one pulse.
- `me_life_o`, `invinc_o` and `game_over_o` update on the clock edge ending the crash cycle, i.e. visible 1 cycle after the strobe.
- The invincibility window covers crash frame N and the following frames; the first crash can be reported again in the frame starting at the `INVINC_FRAMES`-th `v_sync_i` rising edge after the crash.
- Reset values:
  - all strobes 0;
  - `me_life_o = ME_LIFE`;
  - `invinc_o = 0`;
  - `game_over_o = 0`;
  - `hit_done`, `me_done` = 0; `vs_d` = 0.
- Reset mid-frame aborts all state immediately (asynchronous); the first strobe is possible in the first cycle after `rst` falls.

## Test plan
- Bullet over enemy3: `bullet_alpha_i`=1, `enemy_alpha_i`=3'b100 for 20 cycles -> `crash_enemy_bullet_o`=3'b100 and `crash_bullet_o`=1 on the first cycle only. After a `v_sync_i` rising edge, the same overlap gives one more pulse.
- Player crash: `me_alpha_i`=1 with `enemy_alpha_i`=3'b001 -> one `crash_me_enemy_o`=3'b001 pulse; next cycle `me_life_o` 3->2 and `invinc_o`=1. Overlaps in the next 59 frames give no pulse; frame 60 gives a pulse and life 2->1.
- Simultaneous: `me_alpha_i`=`bullet_alpha_i`=1, `enemy_alpha_i`=3'b110 -> `crash_me_enemy_o`=3'b110, `crash_enemy_bullet_o`=0, `crash_bullet_o`=0, life decrements by exactly 1.
- Game over: three player crashes spaced past invincibility -> `me_life_o`=0, `game_over_o`=1. Further overlaps give no strobes, and life stays 0 across frames.
- Enable: `en_i`=0 with overlaps and vsync edges -> no strobes, `invinc_cnt`/`life` frozen. Raising `en_i` resumes from the held values.
- Reset mid-invincibility: assert `rst` with life=1, `invinc_o`=1 -> immediately `me_life_o`=3, `invinc_o`=0, `game_over_o`=0. An overlap in the next cycle pulses.
